// File: rtl/qspi_mem_pkg.sv
// Shared constants and types for the QSPI memory subsystem: the word-memory geometry, the arbiter
// state and owner encodings, and the command codes used by the QSPI command engine.
package qspi_mem_pkg;

  localparam int unsigned AW        = 13;
  localparam int unsigned DW        = 16;
  localparam int unsigned MEM_WORDS = 8192;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;

  typedef enum logic [1:0] {
    OwnNone,
    OwnA,
    OwnB
  } owner_e;

  typedef enum logic [1:0] {
    sIdle,
    sOwnA,
    sOwnB
  } arb_state_e;

  function automatic owner_e state_owner(arb_state_e s);
    unique case (s)
      sOwnA:   return OwnA;
      sOwnB:   return OwnB;
      default: return OwnNone;
    endcase
  endfunction

endpackage

// File: rtl/qspi_mem_port_if.sv
// One requester port of the shared word memory. The requester drives the request side through the
// master modport; the arbiter returns grant and read data through the slave modport.
interface qspi_mem_port_if;

  logic                        REQ;
  logic                        LOCK;
  logic                        WE;
  logic [qspi_mem_pkg::AW-1:0] ADDR;
  logic [qspi_mem_pkg::DW-1:0] WDATA;
  logic                        GNT;
  logic                        RVALID;
  logic [qspi_mem_pkg::DW-1:0] RDATA;

  modport master (
    output REQ, LOCK, WE, ADDR, WDATA,
    input  GNT, RVALID, RDATA
  );

  modport slave (
    input  REQ, LOCK, WE, ADDR, WDATA,
    output GNT, RVALID, RDATA
  );

endinterface

// File: rtl/qspi_arb_stats.sv
// Optional arbiter statistics: saturating grant counters per port and the peak B wait count.
// Instantiated only when QSPI_ARB_STATS_EN is defined.
module qspi_arb_stats (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STAT_CLR,
  input  logic        gnt_a,
  input  logic        gnt_b,
  input  logic [7:0]  starve,
  output logic [15:0] STAT_GNT_A,
  output logic [15:0] STAT_GNT_B,
  output logic [7:0]  STAT_MAXWAIT_B
);

  logic [15:0] gnt_a_q, gnt_b_q;
  logic [7:0]  maxwait_q;

  always_ff @(posedge CLK) begin
    if (RST || STAT_CLR) begin
      gnt_a_q   <= '0;
      gnt_b_q   <= '0;
      maxwait_q <= '0;
    end else begin
      if (gnt_a && gnt_a_q != 16'hFFFF) gnt_a_q <= gnt_a_q + 16'd1;
      if (gnt_b && gnt_b_q != 16'hFFFF) gnt_b_q <= gnt_b_q + 16'd1;
      if (starve > maxwait_q) maxwait_q <= starve;
    end
  end

  assign STAT_GNT_A     = gnt_a_q;
  assign STAT_GNT_B     = gnt_b_q;
  assign STAT_MAXWAIT_B = maxwait_q;

endmodule

// File: rtl/qspi_mem_arbiter.sv
// Two-port arbiter for the single-port word memory: fixed priority to A, starvation guard for B,
// bounded locked bursts. Optional statistics build with QSPI_ARB_STATS_EN.
module qspi_mem_arbiter
  import qspi_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8,
  parameter int unsigned BURST_MAX  = 16
) (
  input  logic          CLK,
  input  logic          RST,
  qspi_mem_port_if.slave a_port,
  qspi_mem_port_if.slave b_port,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_WE,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA
`ifdef QSPI_ARB_STATS_EN
  ,
  input  logic          STAT_CLR,
  output logic [15:0]   STAT_GNT_A,
  output logic [15:0]   STAT_GNT_B,
  output logic [7:0]    STAT_MAXWAIT_B
`endif
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam int unsigned BW = $clog2(BURST_MAX + 1);

  arb_state_e    state_q, state_d;
  owner_e        owner;
  logic [SW-1:0] starve_q, starve_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          rvalid_a_q, rvalid_b_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          gnt_a, gnt_b;
  logic          release_a, release_b, arbitrate;

  assign owner = state_owner(state_q);

  always_comb begin
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    release_a = 1'b0;
    release_b = 1'b0;
    arbitrate = 1'b0;
    state_d   = state_q;
    burst_d   = burst_q;

    unique case (owner)
      OwnA: begin
        if (!a_port.LOCK || burst_q == BW'(BURST_MAX) || (!a_port.REQ && b_port.REQ)) begin
          release_a = 1'b1;
          arbitrate = 1'b1;
        end else begin
          gnt_a = a_port.REQ;
        end
      end
      OwnB: begin
        if (!b_port.LOCK || burst_q == BW'(BURST_MAX) || (!b_port.REQ && a_port.REQ)) begin
          release_b = 1'b1;
          arbitrate = 1'b1;
        end else begin
          gnt_b = b_port.REQ;
        end
      end
      default: arbitrate = 1'b1;
    endcase

    if (arbitrate) begin
      // On a tie the port that just gave up ownership loses; the starvation guard only
      // applies when nobody is being released.
      if (a_port.REQ && b_port.REQ) begin
        if (release_a || (!release_b && starve_q == SW'(STARVE_MAX))) gnt_b = 1'b1;
        else                                                            gnt_a = 1'b1;
      end else begin
        gnt_a = a_port.REQ;
        gnt_b = b_port.REQ;
      end
      if (gnt_a && a_port.LOCK)      state_d = sOwnA;
      else if (gnt_b && b_port.LOCK) state_d = sOwnB;
      else                           state_d = sIdle;
      burst_d = (state_d == sIdle) ? '0 : BW'(1);
    end else if (gnt_a || gnt_b) begin
      burst_d = burst_q + 1'b1;
    end

    if (RST) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end

    if (b_port.REQ && !gnt_b) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    end else begin
      starve_d = '0;
    end
  end

  always_comb begin
    if (gnt_a) begin
      MEM_ADDR  = a_port.ADDR;
      MEM_WDATA = a_port.WDATA;
    end else if (gnt_b) begin
      MEM_ADDR  = b_port.ADDR;
      MEM_WDATA = b_port.WDATA;
    end else begin
      MEM_ADDR  = addr_q;
      MEM_WDATA = wdata_q;
    end
    MEM_WE = (gnt_a & a_port.WE) | (gnt_b & b_port.WE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= sIdle;
      starve_q   <= '0;
      burst_q    <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      burst_q    <= burst_d;
      rvalid_a_q <= gnt_a & ~a_port.WE;
      rvalid_b_q <= gnt_b & ~b_port.WE;
      addr_q     <= MEM_ADDR;
      wdata_q    <= MEM_WDATA;
    end
  end

  // Reset in the cycle after a read grant drops the pending read response.
  assign a_port.GNT    = gnt_a;
  assign b_port.GNT    = gnt_b;
  assign a_port.RVALID = rvalid_a_q & ~RST;
  assign b_port.RVALID = rvalid_b_q & ~RST;
  assign a_port.RDATA  = MEM_RDATA;
  assign b_port.RDATA  = MEM_RDATA;

`ifdef QSPI_ARB_STATS_EN
  qspi_arb_stats u_stats (
    .CLK            (CLK),
    .RST            (RST),
    .STAT_CLR       (STAT_CLR),
    .gnt_a          (gnt_a),
    .gnt_b          (gnt_b),
    .starve         (8'(starve_q)),
    .STAT_GNT_A     (STAT_GNT_A),
    .STAT_GNT_B     (STAT_GNT_B),
    .STAT_MAXWAIT_B (STAT_MAXWAIT_B)
  );
`endif

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Scoreboard bench for qspi_mem_arbiter: per-cycle expectations are queued by the stimulus and
// popped by a negedge monitor; a small registered-read memory sits behind the arbiter.
module tb_qspi_mem_arbiter;
  import qspi_mem_pkg::*;

  typedef struct packed {
    logic          req;
    logic          lock;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } preq_t;

  typedef struct packed {
    logic [4:0]    flags;  // {gnt_a, gnt_b, rvalid_a, rvalid_b, mem_we}
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RST;
  logic [AW-1:0] MEM_ADDR;
  logic          MEM_WE;
  logic [DW-1:0] MEM_WDATA;
  logic [DW-1:0] MEM_RDATA;
  logic [DW-1:0] mem [0:MEM_WORDS-1];

  int checks = 0;
  int errors = 0;

  exp_t          exp_q[$];
  logic [DW-1:0] rd_a_q[$];
  logic [DW-1:0] rd_b_q[$];
  logic          pend_a = 1'b0, pend_b = 1'b0;
  logic [DW-1:0] pend_a_data = '0, pend_b_data = '0;
  logic [AW-1:0] last_addr = '0;

  qspi_mem_port_if a_if ();
  qspi_mem_port_if b_if ();

`ifdef QSPI_ARB_STATS_EN
  logic        STAT_CLR = 1'b0;
  logic [15:0] STAT_GNT_A, STAT_GNT_B;
  logic [7:0]  STAT_MAXWAIT_B;
`endif

  qspi_mem_arbiter #(
    .STARVE_MAX (8),
    .BURST_MAX  (16)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .a_port         (a_if.slave),
    .b_port         (b_if.slave),
    .MEM_ADDR       (MEM_ADDR),
    .MEM_WE         (MEM_WE),
    .MEM_WDATA      (MEM_WDATA),
    .MEM_RDATA      (MEM_RDATA)
`ifdef QSPI_ARB_STATS_EN
    ,
    .STAT_CLR       (STAT_CLR),
    .STAT_GNT_A     (STAT_GNT_A),
    .STAT_GNT_B     (STAT_GNT_B),
    .STAT_MAXWAIT_B (STAT_MAXWAIT_B)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory array with 1-cycle registered read.
  always @(posedge CLK) begin
    if (MEM_WE) mem[MEM_ADDR] <= MEM_WDATA;
    MEM_RDATA <= mem[MEM_ADDR];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("gnt/rvalid/we", 32'({a_if.GNT, b_if.GNT, a_if.RVALID, b_if.RVALID, MEM_WE}),
          32'(e.flags));
      chk("mem_addr", 32'(MEM_ADDR), 32'(e.addr));
      if (e.flags[0]) chk("mem_wdata", 32'(MEM_WDATA), 32'(e.wdata));
      if (a_if.RVALID && rd_a_q.size() > 0) chk("a_rdata", 32'(a_if.RDATA), 32'(rd_a_q.pop_front()));
      if (b_if.RVALID && rd_b_q.size() > 0) chk("b_rdata", 32'(b_if.RDATA), 32'(rd_b_q.pop_front()));
    end
  end

  function automatic preq_t idle();
    return '0;
  endfunction

  function automatic preq_t rd(input logic [AW-1:0] addr, input logic lock);
    return '{req: 1'b1, lock: lock, we: 1'b0, addr: addr, wdata: '0};
  endfunction

  function automatic preq_t wr(input logic [AW-1:0] addr, input logic [DW-1:0] d, input logic lock);
    return '{req: 1'b1, lock: lock, we: 1'b1, addr: addr, wdata: d};
  endfunction

  // Drive one cycle and queue what the monitor must see during it.
  task automatic cyc(input preq_t pa, input preq_t pb, input logic rst, input logic ga,
                     input logic gb, input logic [DW-1:0] rda, input logic [DW-1:0] rdb);
    exp_t e;
    RST        = rst;
    a_if.REQ   = pa.req;  a_if.LOCK = pa.lock; a_if.WE = pa.we;
    a_if.ADDR  = pa.addr; a_if.WDATA = pa.wdata;
    b_if.REQ   = pb.req;  b_if.LOCK = pb.lock; b_if.WE = pb.we;
    b_if.ADDR  = pb.addr; b_if.WDATA = pb.wdata;
    if (pend_a && !rst) rd_a_q.push_back(pend_a_data);
    if (pend_b && !rst) rd_b_q.push_back(pend_b_data);
    if (ga)      last_addr = pa.addr;
    else if (gb) last_addr = pb.addr;
    e.flags = {ga, gb, pend_a && !rst, pend_b && !rst, (ga && pa.we) || (gb && pb.we)};
    e.addr  = last_addr;
    e.wdata = ga ? pa.wdata : pb.wdata;
    exp_q.push_back(e);
    pend_a = ga && !pa.we; pend_a_data = rda;
    pend_b = gb && !pb.we; pend_b_data = rdb;
    @(posedge CLK);
    #1;
    if (rst) last_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    logic bdone;
    RST = 1'b1;
    a_if.REQ = 1'b0; a_if.LOCK = 1'b0; a_if.WE = 1'b0; a_if.ADDR = '0; a_if.WDATA = '0;
    b_if.REQ = 1'b0; b_if.LOCK = 1'b0; b_if.WE = 1'b0; b_if.ADDR = '0; b_if.WDATA = '0;
    @(posedge CLK);
    #1;

    // Reset, idle reset state, B preload then A read of 0x0010.
    cyc(idle(), idle(), 1'b1, 1'b0, 1'b0, '0, '0);
    cyc(idle(), idle(), 1'b1, 1'b0, 1'b0, '0, '0);
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);
    cyc(idle(), wr(13'h0010, 16'h1234, 1'b0), 1'b0, 1'b0, 1'b1, '0, '0);
    cyc(rd(13'h0010, 1'b0), idle(), 1'b0, 1'b1, 1'b0, 16'h1234, '0);
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);

    // Both request without lock: B wins every 9th cycle.
    for (int i = 1; i <= 27; i++) begin
      cyc(wr(13'h0200, 16'hA000 + 16'(i), 1'b0), wr(13'h0300, 16'hB000 + 16'(i), 1'b0),
          1'b0, (i % 9) != 0, (i % 9) == 0, '0, '0);
    end
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);

    // Locked burst of 20 writes vs a single held B read: A 16, B 1, A 4.
    k = 0;
    bdone = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      cyc(wr(13'h0100 + 13'(k), 16'hC000 + 16'(k), 1'b1),
          bdone ? idle() : rd(13'h0010, 1'b0), 1'b0, c != 17, c == 17, '0, 16'h1234);
      if (c == 17) bdone = 1'b1;
      else         k++;
    end
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);
    for (int j = 0; j < 20; j++) begin
      cyc(rd(13'h0100 + 13'(j), 1'b0), idle(), 1'b0, 1'b1, 1'b0, 16'hC000 + 16'(j), '0);
    end
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);

    // Write-then-read at the top address across ports.
    cyc(idle(), wr(13'h1FFF, 16'hBEEF, 1'b0), 1'b0, 1'b0, 1'b1, '0, '0);
    cyc(rd(13'h1FFF, 1'b0), idle(), 1'b0, 1'b1, 1'b0, 16'hBEEF, '0);
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);

    // Reset in the cycle after a locked read grant suppresses the response.
    cyc(rd(13'h0010, 1'b1), idle(), 1'b0, 1'b1, 1'b0, 16'h1234, '0);
    cyc(rd(13'h0010, 1'b1), rd(13'h1FFF, 1'b0), 1'b1, 1'b0, 1'b0, '0, '0);
    cyc(idle(), rd(13'h1FFF, 1'b0), 1'b0, 1'b0, 1'b1, '0, 16'hBEEF);
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);

`ifdef QSPI_ARB_STATS_EN
    STAT_CLR = 1'b1;
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);
    STAT_CLR = 1'b0;
    for (int i = 1; i <= 90; i++) begin
      cyc(wr(13'h0400, 16'(i), 1'b0), wr(13'h0500, 16'(i), 1'b0),
          1'b0, (i % 9) != 0, (i % 9) == 0, '0, '0);
    end
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);
    chk("stat_gnt_a", 32'(STAT_GNT_A), 32'd80);
    chk("stat_gnt_b", 32'(STAT_GNT_B), 32'd10);
    chk("stat_maxwait_b", 32'(STAT_MAXWAIT_B), 32'd8);
    STAT_CLR = 1'b1;
    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);
    STAT_CLR = 1'b0;
    chk("stat_clr", 32'({STAT_GNT_A, STAT_GNT_B[7:0], STAT_MAXWAIT_B}), 32'd0);
`endif

    cyc(idle(), idle(), 1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge CLK);
    chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("a_reads_returned", 32'(rd_a_q.size()), 32'd0);
    chk("b_reads_returned", 32'(rd_b_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
